// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//
// Shared definitions for the Memory pipeline stage:
//   - lw / sw primary opcodes
//   - default data-memory geometry (depth in words, byte base address)
//   - the E/M pipeline register layout
//   - small decode helpers used by the stage logic
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    // Primary opcodes (instr[31:26]) of the only two memory instructions.
    localparam logic [5:0] OPC_LW = 6'b100011;
    localparam logic [5:0] OPC_SW = 6'b101011;

    // Default data-memory geometry.
    localparam int          DM_WORDS_DEFAULT = 1024;
    localparam logic [31:0] DM_BASE_DEFAULT  = 32'h0000_0000;

    // Memory operation carried by the instruction currently in M.
    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } memOp_e;

    // Contents of the E/M pipeline register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] ao;
        logic [31:0] rt;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        grfwe;
        logic [3:0]  tnew;
    } emReg_t;

    // An all-zero register is a nop: opcode 0 is neither lw nor sw and
    // no register write is requested.
    localparam emReg_t EM_NOP = '0;

    // Classify an instruction by its primary opcode.
    function automatic memOp_e decodeMemOp(input logic [5:0] opcode);
        case (opcode)
            OPC_LW:  return MEM_OP_LOAD;
            OPC_SW:  return MEM_OP_STORE;
            default: return MEM_OP_NONE;
        endcase
    endfunction

    // Cycles-until-result counter after one more stage has elapsed;
    // saturates at zero once the result is already available.
    function automatic logic [3:0] decTnew(input logic [3:0] tnew);
        return (tnew == 4'd0) ? 4'd0 : tnew - 4'd1;
    endfunction

endpackage

// File: rtl/mem_stage_dm.sv
// ---------------------------------------------------------------------------
// mem_stage_dm
//
// Word-addressed data memory for the Memory stage. Writes take effect at the
// rising clock edge; reads are combinational so a load sees a store that
// completed at the edge it entered M on. Reset clears every word.
//
// Ports:
//   clk    in   clock, writes on rising edge
//   reset  in   asynchronous active-low clear of all words
//   we     in   write enable
//   idx    in   word index
//   wdata  in   32-bit write data
//   rdata  out  32-bit combinational read data at idx
// ---------------------------------------------------------------------------
module mem_stage_dm #(
    parameter int DM_WORDS = 1024,
    parameter int IDX_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [DM_WORDS];

    // Storage array. The reset branch has priority over the write, so an
    // edge that arrives while reset is held low never commits a store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    assign rdata = r_mem[idx];

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory stage of a 5-stage MIPS-style pipeline. Holds the E/M pipeline
// register, performs lw/sw against a private word-addressed data memory,
// produces the write-back fields for W and a forwarding source for D/E.
//
// Parameters:
//   DM_WORDS  data-memory depth in 32-bit words
//   DM_BASE   byte address of data-memory word 0
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-low reset
//   e_instr      in   instruction leaving Execute
//   e_pc         in   PC of that instruction
//   e_ao         in   ALU result (byte address for lw/sw)
//   e_rt         in   forwarded rt value (store data)
//   e_a3         in   destination register from Execute
//   e_wd         in   write-back data from Execute
//   e_grfwe      in   register-file write enable from Execute
//   e_tnew       in   cycles until result is available, from Execute
//   flush        in   load a bubble into E/M at the next edge
//   m_instr      out  instruction in M
//   m_pc         out  PC of instruction in M
//   m_a3         out  destination register toward W
//   m_wd         out  write-back data toward W
//   m_grfwe      out  register-file write enable toward W
//   m_tnew       out  tnew after this stage
//   m_fwd_a3     out  forwarding destination register
//   m_fwd_data   out  forwarding data
//   m_fwd_valid  out  forwarding data is final and usable
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          DM_WORDS = DM_WORDS_DEFAULT,
    parameter logic [31:0] DM_BASE  = DM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] e_instr,
    input  logic [31:0] e_pc,
    input  logic [31:0] e_ao,
    input  logic [31:0] e_rt,
    input  logic [4:0]  e_a3,
    input  logic [31:0] e_wd,
    input  logic        e_grfwe,
    input  logic [3:0]  e_tnew,
    input  logic        flush,
    output logic [31:0] m_instr,
    output logic [31:0] m_pc,
    output logic [4:0]  m_a3,
    output logic [31:0] m_wd,
    output logic        m_grfwe,
    output logic [3:0]  m_tnew,
    output logic [4:0]  m_fwd_a3,
    output logic [31:0] m_fwd_data,
    output logic        m_fwd_valid
);

    localparam int IDX_W = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

    // One past the last valid byte address, kept 33 bits wide so a memory
    // that ends exactly at the top of the address space does not wrap.
    localparam logic [32:0] DM_LIMIT = {1'b0, DM_BASE} + (33'(DM_WORDS) << 2);

    emReg_t            r_em;
    memOp_e            w_op;
    logic [31:0]       w_offset;
    logic              w_inRange;
    logic [IDX_W-1:0]  w_idx;
    logic              w_we;
    logic [31:0]       w_dmRdata;
    logic [31:0]       w_rdata;
    logic              w_unusedOffset;

    // E/M pipeline register. A flush turns the slot into a nop so the
    // bubble neither stores nor writes back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_em <= EM_NOP;
        end else if (flush) begin
            r_em <= EM_NOP;
        end else begin
            r_em <= '{
                instr: e_instr,
                pc:    e_pc,
                ao:    e_ao,
                rt:    e_rt,
                a3:    e_a3,
                wd:    e_wd,
                grfwe: e_grfwe,
                tnew:  e_tnew
            };
        end
    end

    assign w_op = decodeMemOp(r_em.instr[31:26]);

    // Accesses are whole words: the two low address bits are dropped when
    // forming the index. Only the index bits of the offset are meaningful,
    // the rest are folded into a sink to keep them visibly consumed.
    assign w_offset       = r_em.ao - DM_BASE;
    assign w_idx          = w_offset[IDX_W+1:2];
    assign w_unusedOffset = ^w_offset;

    assign w_inRange = (r_em.ao >= DM_BASE) && ({1'b0, r_em.ao} < DM_LIMIT);

    // A store in M commits at the following edge, which is exactly when
    // the next instruction enters M, so a back-to-back load sees it.
    assign w_we = (w_op == MEM_OP_STORE) && w_inRange;

    mem_stage_dm #(
        .DM_WORDS (DM_WORDS),
        .IDX_W    (IDX_W)
    ) dm (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .idx   (w_idx),
        .wdata (r_em.rt),
        .rdata (w_dmRdata)
    );

    assign w_rdata = w_inRange ? w_dmRdata : 32'h0;

    // Write-back fields toward W. Loads take their destination from the
    // rt field of the instruction; a load into $0 is not a real write.
    always_comb begin
        m_instr = r_em.instr;
        m_pc    = r_em.pc;
        m_a3    = r_em.a3;
        m_wd    = r_em.wd;
        m_grfwe = r_em.grfwe;
        m_tnew  = decTnew(r_em.tnew);
        case (w_op)
            MEM_OP_LOAD: begin
                m_a3    = r_em.instr[20:16];
                m_wd    = w_rdata;
                m_grfwe = |r_em.instr[20:16];
            end
            MEM_OP_STORE: begin
                m_a3    = '0;
                m_grfwe = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Forwarding from M is only offered for results already final here.
    // Load data is excluded: it comes out of memory late in the cycle and
    // consumers must wait for it in W instead.
    assign m_fwd_a3    = m_a3;
    assign m_fwd_data  = r_em.wd;
    assign m_fwd_valid = m_grfwe && (m_tnew == 4'd0) && (w_op != MEM_OP_LOAD);

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Scoreboard bench for mem_stage. The driver issues one instruction per
// cycle and pushes the response expected from a word-array model of the
// stage; a monitor pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int          DM_WORDS = 1024;
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [5:0]  OPC_ORI  = 6'b001101;

    logic        clk;
    logic        reset;
    logic [31:0] eInstr;
    logic [31:0] ePc;
    logic [31:0] eAo;
    logic [31:0] eRt;
    logic [4:0]  eA3;
    logic [31:0] eWd;
    logic        eGrfwe;
    logic [3:0]  eTnew;
    logic        flush;
    logic [31:0] mInstr;
    logic [31:0] mPc;
    logic [4:0]  mA3;
    logic [31:0] mWd;
    logic        mGrfwe;
    logic [3:0]  mTnew;
    logic [4:0]  mFwdA3;
    logic [31:0] mFwdData;
    logic        mFwdValid;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a3;
        logic [31:0] wd;
        logic [31:0] grfwe;
        logic [31:0] tnew;
        logic [31:0] fwdA3;
        logic [31:0] fwdData;
        logic [31:0] fwdValid;
        logic        wdCare;
    } expect_t;

    expect_t     expQ[$];
    logic [31:0] modelMem [DM_WORDS];
    int          errors = 0;
    int          checks = 0;

    mem_stage #(
        .DM_WORDS (DM_WORDS),
        .DM_BASE  (DM_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .e_instr     (eInstr),
        .e_pc        (ePc),
        .e_ao        (eAo),
        .e_rt        (eRt),
        .e_a3        (eA3),
        .e_wd        (eWd),
        .e_grfwe     (eGrfwe),
        .e_tnew      (eTnew),
        .flush       (flush),
        .m_instr     (mInstr),
        .m_pc        (mPc),
        .m_a3        (mA3),
        .m_wd        (mWd),
        .m_grfwe     (mGrfwe),
        .m_tnew      (mTnew),
        .m_fwd_a3    (mFwdA3),
        .m_fwd_data  (mFwdData),
        .m_fwd_valid (mFwdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic expect_t zeroExp();
        expect_t e;
        e.instr    = '0;
        e.pc       = '0;
        e.a3       = '0;
        e.wd       = '0;
        e.grfwe    = '0;
        e.tnew     = '0;
        e.fwdA3    = '0;
        e.fwdData  = '0;
        e.fwdValid = '0;
        e.wdCare   = 1'b1;
        return e;
    endfunction

    // Reference model: the memory is a plain array updated in program order.
    // Because a store lands before the next instruction reads, applying each
    // store right after computing its own response gives the right view.
    function automatic expect_t modelTxn(input logic [31:0] instr, input logic [31:0] pc,
                                         input logic [31:0] ao, input logic [31:0] rt,
                                         input logic [4:0] a3, input logic [31:0] wd,
                                         input logic grfwe, input logic [3:0] tnew,
                                         input logic fl);
        expect_t     e;
        longint      addr;
        longint      base;
        bit          inRange;
        int          idx;
        logic [5:0]  opc;
        logic [4:0]  rtField;
        int          tnewAfter;
        bit          isLw;
        bit          isSw;
        e = zeroExp();
        if (fl) return e;
        addr    = longint'(ao);
        base    = longint'(DM_BASE);
        inRange = (addr >= base) && (addr < base + 4 * DM_WORDS);
        idx     = int'((addr - base) / 4);
        opc     = instr[31:26];
        rtField = instr[20:16];
        isLw    = (opc == OPC_LW);
        isSw    = (opc == OPC_SW);
        tnewAfter = (int'(tnew) > 0) ? int'(tnew) - 1 : 0;
        e.instr   = instr;
        e.pc      = pc;
        e.tnew    = 32'(tnewAfter);
        e.fwdData = wd;
        if (isLw) begin
            e.a3    = 32'(rtField);
            e.wd    = inRange ? modelMem[idx] : 32'h0;
            e.grfwe = (rtField != 0) ? 32'd1 : 32'd0;
        end else if (isSw) begin
            e.a3     = 32'd0;
            e.grfwe  = 32'd0;
            e.wd     = wd;
            e.wdCare = 1'b0;
            if (inRange) modelMem[idx] = rt;
        end else begin
            e.a3    = 32'(a3);
            e.wd    = wd;
            e.grfwe = 32'(grfwe);
        end
        e.fwdA3    = e.a3;
        e.fwdValid = (e.grfwe == 1 && tnewAfter == 0 && !isLw) ? 32'd1 : 32'd0;
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] ao, input logic [31:0] rt,
                                 input logic [4:0] a3, input logic [31:0] wd,
                                 input logic grfwe, input logic [3:0] tnew,
                                 input logic fl);
        @(negedge clk);
        reset  = 1'b1;
        eInstr = instr;
        ePc    = pc;
        eAo    = ao;
        eRt    = rt;
        eA3    = a3;
        eWd    = wd;
        eGrfwe = grfwe;
        eTnew  = tnew;
        flush  = fl;
        expQ.push_back(modelTxn(instr, pc, ao, rt, a3, wd, grfwe, tnew, fl));
    endtask

    // Hold reset low for n edges; the stage must clear without waiting for
    // a clock and the model forgets all stores, including one still in M.
    task automatic doReset(input int n);
        @(negedge clk);
        reset  = 1'b0;
        eInstr = '0;
        ePc    = '0;
        eAo    = '0;
        eRt    = '0;
        eA3    = '0;
        eWd    = '0;
        eGrfwe = 1'b0;
        eTnew  = '0;
        flush  = 1'b0;
        #1;
        checkOutput("asyncClear",
                    mInstr | mPc | mWd | mFwdData | 32'(mA3) | 32'(mFwdA3)
                    | 32'(mGrfwe) | 32'(mFwdValid) | 32'(mTnew), 32'h0);
        for (int i = 0; i < DM_WORDS; i++) modelMem[i] = 32'h0;
        expQ.push_back(zeroExp());
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            expQ.push_back(zeroExp());
        end
    endtask

    function automatic logic [31:0] mkInstr(input logic [5:0] opc, input logic [4:0] rtField);
        logic [4:0]  rs;
        logic [15:0] imm;
        rs  = 5'($urandom);
        imm = 16'($urandom);
        return {opc, rs, rtField, imm};
    endfunction

    // Monitor: one response per rising edge, compared shortly after it.
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("m_instr", mInstr, e.instr);
            checkOutput("m_pc", mPc, e.pc);
            checkOutput("m_a3", 32'(mA3), e.a3);
            if (e.wdCare) checkOutput("m_wd", mWd, e.wd);
            checkOutput("m_grfwe", 32'(mGrfwe), e.grfwe);
            checkOutput("m_tnew", 32'(mTnew), e.tnew);
            checkOutput("m_fwd_a3", 32'(mFwdA3), e.fwdA3);
            checkOutput("m_fwd_data", mFwdData, e.fwdData);
            checkOutput("m_fwd_valid", 32'(mFwdValid), e.fwdValid);
        end
    end

    initial begin
        logic [5:0]  opc;
        logic [31:0] ao;
        int          sel;
        reset  = 1'b0;
        eInstr = '0;
        ePc    = '0;
        eAo    = '0;
        eRt    = '0;
        eA3    = '0;
        eWd    = '0;
        eGrfwe = 1'b0;
        eTnew  = '0;
        flush  = 1'b0;
        for (int i = 0; i < DM_WORDS; i++) modelMem[i] = 32'h0;

        doReset(3);

        // Word 5 is empty after reset.
        applyStimulus(mkInstr(OPC_LW, 5'd8), 32'h0000_3000, 32'h14, $urandom, 5'd1, $urandom, 1'b1, 4'd2, 1'b0);
        // Store then immediate load of the same word.
        applyStimulus(mkInstr(OPC_SW, 5'd9), 32'h0000_3004, 32'h14, 32'hDEAD_BEEF, 5'd4, 32'h1111, 1'b1, 4'd0, 1'b0);
        applyStimulus(mkInstr(OPC_LW, 5'd8), 32'h0000_3008, 32'h14, $urandom, 5'd2, 32'h2222, 1'b0, 4'd1, 1'b0);
        // Low address bits are ignored.
        applyStimulus(mkInstr(OPC_SW, 5'd3), 32'h0000_300C, 32'h103, 32'hCAFE_0103, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        applyStimulus(mkInstr(OPC_LW, 5'd7), 32'h0000_3010, 32'h100, $urandom, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        // Last word in range.
        applyStimulus(mkInstr(OPC_SW, 5'd3), 32'h0000_3014, 32'hFFF, 32'h1234_5678, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        applyStimulus(mkInstr(OPC_LW, 5'd6), 32'h0000_3018, 32'hFFC, $urandom, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        // First address past the end, and the very top of the address space.
        applyStimulus(mkInstr(OPC_SW, 5'd3), 32'h0000_301C, 32'h1000, 32'hBAD0_1000, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        applyStimulus(mkInstr(OPC_LW, 5'd5), 32'h0000_3020, 32'h1000, $urandom, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        applyStimulus(mkInstr(OPC_SW, 5'd3), 32'h0000_3024, 32'hFFFF_FFFC, 32'hBAD0_FFFC, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        applyStimulus(mkInstr(OPC_LW, 5'd5), 32'h0000_3028, 32'hFFFF_FFFC, $urandom, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        applyStimulus(mkInstr(OPC_LW, 5'd6), 32'h0000_302C, 32'h0, $urandom, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        // Load into $0 never writes back.
        applyStimulus(mkInstr(OPC_LW, 5'd0), 32'h0000_3030, 32'h14, $urandom, 5'd9, $urandom, 1'b1, 4'd0, 1'b0);
        // ALU result ready in M is forwarded; flushed copy is a bubble.
        applyStimulus(mkInstr(OPC_ORI, 5'd3), 32'h0000_3034, $urandom, $urandom, 5'd3, 32'd7, 1'b1, 4'd1, 1'b0);
        applyStimulus(mkInstr(OPC_ORI, 5'd3), 32'h0000_3038, $urandom, $urandom, 5'd3, 32'd7, 1'b1, 4'd1, 1'b1);
        applyStimulus(mkInstr(OPC_ORI, 5'd3), 32'h0000_303C, $urandom, $urandom, 5'd3, 32'd7, 1'b1, 4'd2, 1'b0);
        // Reset while a store sits in M loses the store.
        applyStimulus(mkInstr(OPC_SW, 5'd3), 32'h0000_3040, 32'h20, 32'h5A5A_A5A5, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);
        doReset(2);
        applyStimulus(mkInstr(OPC_LW, 5'd8), 32'h0000_3044, 32'h20, $urandom, 5'd0, $urandom, 1'b0, 4'd0, 1'b0);

        // Random traffic concentrated on a few words so loads hit stores.
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      opc = OPC_LW;
            else if (sel < 8) opc = OPC_SW;
            else begin
                opc = 6'($urandom);
                if (opc == OPC_LW || opc == OPC_SW) opc = OPC_ORI;
            end
            if ($urandom_range(0, 7) == 0) ao = $urandom;
            else ao = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            applyStimulus(mkInstr(opc, 5'($urandom_range(0, 7))), $urandom, ao, $urandom,
                          5'($urandom), $urandom, 1'($urandom), 4'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) == 0));
        end

        for (int w = 0; w < 20 && expQ.size() > 0; w++) @(posedge clk);
        #2;
        checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
